// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions (state encodings, frame constants)
//                used by both the receiver and the transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Number of data bits in one UART frame.
    localparam int UART_DATA_BITS = 8;

    // Width of the data-bit index.
    localparam int UART_IDX_W = $clog2(UART_DATA_BITS);

    // Frame-level state machine encoding shared by RX and TX.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Two-flop synchronizer for a single asynchronous input.
//                Both flops come out of reset at RESET_VAL.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second filters it.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            meta     <= RESET_VAL;
            sync_out <= RESET_VAL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Start bit is qualified at its midpoint,
//                data and stop bits are sampled one bit period apart from
//                there. Good frames pulse o_RX_DV, bad stop bits pulse
//                o_Frame_Err.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [UART_IDX_W-1:0] LAST_IDX = UART_IDX_W'(UART_DATA_BITS - 1);

    uart_state_t                  state;
    logic [CNT_W-1:0]             clk_count;
    logic [UART_IDX_W-1:0]        bit_index;
    logic [UART_DATA_BITS-1:0]    shift_reg;
    logic                         rx_s;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_Clock  (i_Clock),
        .i_Rst_L  (i_Rst_L),
        .async_in (i_RX_Serial),
        .sync_out (rx_s)
    );

    // Frame state machine with registered outputs; pulses default low every cycle.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            clk_count   <= '0;
            bit_index   <= '0;
            shift_reg   <= '0;
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_RX_Active <= 1'b0;
            o_RX_Byte   <= 8'h00;
        end else begin
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;

            case (state)
                IDLE: begin
                    clk_count <= '0;
                    bit_index <= '0;
                    if (rx_s == 1'b0) begin
                        state       <= START;
                        o_RX_Active <= 1'b1;
                    end
                end

                // Re-check the line at mid start bit to reject short glitches.
                START: begin
                    if (clk_count == HALF_CNT) begin
                        clk_count <= '0;
                        if (rx_s == 1'b0) begin
                            state <= DATA;
                        end else begin
                            state       <= IDLE;
                            o_RX_Active <= 1'b0;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_count < LAST_CNT) begin
                        clk_count <= clk_count + 1'b1;
                    end else begin
                        clk_count            <= '0;
                        shift_reg[bit_index] <= rx_s;
                        if (bit_index == LAST_IDX) begin
                            bit_index <= '0;
                            state     <= STOP;
                        end else begin
                            bit_index <= bit_index + 1'b1;
                        end
                    end
                end

                // Output byte is only updated on a correctly framed stop bit.
                STOP: begin
                    if (clk_count < LAST_CNT) begin
                        clk_count <= clk_count + 1'b1;
                    end else begin
                        clk_count   <= '0;
                        o_RX_Active <= 1'b0;
                        state       <= CLEANUP;
                        if (rx_s == 1'b1) begin
                            o_RX_DV   <= 1'b1;
                            o_RX_Byte <= shift_reg;
                        end else begin
                            o_Frame_Err <= 1'b1;
                        end
                    end
                end

                CLEANUP: begin
                    state <= IDLE;
                end

                default: begin
                    state       <= IDLE;
                    clk_count   <= '0;
                    bit_index   <= '0;
                    o_RX_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_rx
`default_nettype wire
